// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller: active-low segment
// patterns (bit0 = a ... bit6 = g) and a width helper for counters.
package ssd_pkg;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int clog2w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_to_seg
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Double-buffered multiplexed seven-segment scanner. Loads land in a staging
// set and are committed to the displayed set only at a frame boundary.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  err_in,
    input  logic                  blank_lz,
    input  logic                  load,
    output logic                  load_ack,
    output logic                  frame_tick,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg_out,
    output logic                  dp_out
);

    localparam int PW = clog2w(PRESCALE);
    localparam int IW = clog2w(DIGITS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  pending_q, pending_d;
    logic [4*DIGITS-1:0]   stg_value_q, stg_value_d;
    logic [DIGITS-1:0]     stg_dp_q, stg_dp_d;
    logic                  stg_err_q, stg_err_d;
    logic                  stg_blz_q, stg_blz_d;
    logic [4*DIGITS-1:0]   act_value_q, act_value_d;
    logic [DIGITS-1:0]     act_dp_q, act_dp_d;
    logic                  act_err_q, act_err_d;
    logic                  act_blz_q, act_blz_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  load_ack_q, load_ack_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  wrap;
    logic                  boundary;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  upper_zero;
    logic [6:0]            hex_seg;

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nib),
        .seg    (hex_seg)
    );

    always_comb begin
        presc_d      = presc_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        stg_value_d  = stg_value_q;
        stg_dp_d     = stg_dp_q;
        stg_err_d    = stg_err_q;
        stg_blz_d    = stg_blz_q;
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_err_d    = act_err_q;
        act_blz_d    = act_blz_q;
        an_d         = '1;
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        cur_nib      = 4'h0;
        cur_dp       = 1'b0;
        upper_zero   = 1'b1;

        wrap         = (presc_q == PRESC_MAX);
        boundary     = wrap && (idx_q == IDX_MAX);
        load_ack_d   = boundary && pending_q;
        frame_tick_d = boundary;

        if (wrap) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end

        // Commit uses pre-edge staging, so a load landing on the boundary
        // edge is held for the next frame rather than committed early.
        if (boundary && pending_q) begin
            act_value_d = stg_value_q;
            act_dp_d    = stg_dp_q;
            act_err_d   = stg_err_q;
            act_blz_d   = stg_blz_q;
        end

        if (load) begin
            stg_value_d = value_in;
            stg_dp_d    = dp_in;
            stg_err_d   = err_in;
            stg_blz_d   = blank_lz;
            pending_d   = 1'b1;
        end else if (boundary) begin
            pending_d   = 1'b0;
        end

        for (int i = 0; i < DIGITS; i++) begin
            an_d[i] = (idx_q != IW'(i));
            if (idx_q == IW'(i)) begin
                cur_nib = act_value_q[4*i +: 4];
                cur_dp  = act_dp_q[i];
            end
            if ((IW'(i) >= idx_q) && (act_value_q[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end

        if (act_err_q) begin
            seg_d = SEG_DASH;
            dp_d  = 1'b1;
        end else if (act_blz_q && (idx_q != '0) && upper_zero) begin
            seg_d = SEG_BLANK;
            dp_d  = ~cur_dp;
        end else begin
            seg_d = hex_seg;
            dp_d  = ~cur_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            stg_value_q  <= '0;
            stg_dp_q     <= '0;
            stg_err_q    <= 1'b0;
            stg_blz_q    <= 1'b0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_err_q    <= 1'b0;
            act_blz_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            load_ack_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            stg_value_q  <= stg_value_d;
            stg_dp_q     <= stg_dp_d;
            stg_err_q    <= stg_err_d;
            stg_blz_q    <= stg_blz_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_err_q    <= act_err_d;
            act_blz_q    <= act_blz_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            load_ack_q   <= load_ack_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign load_ack   = load_ack_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Frame-level scoreboard bench for ssd_scan_ctrl with DIGITS=4, PRESCALE=4.
// Each expected frame packs {load_ack, dp_out per digit, seg digit3..digit0}.
module tb_ssd_scan_ctrl;
  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int FW       = 33;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in    = '0;
  logic        err_in   = 1'b0;
  logic        blank_lz = 1'b0;
  logic        load     = 1'b0;
  logic        load_ack;
  logic        frame_tick;
  logic [3:0]  an;
  logic [6:0]  seg_out;
  logic        dp_out;

  int vectors     = 0;
  int miscompares = 0;
  logic [FW-1:0] exp_q[$];

  logic [6:0]  seg_seen [4];
  logic [3:0]  dp_seen;
  logic [3:0]  seen;
  logic [3:0]  prev_an;
  logic [3:0]  exp_an;
  logic [FW-1:0] obs;
  int          cyc_tick;
  int          cyc_digit;
  int          dsel;

  ssd_scan_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .err_in     (err_in),
    .blank_lz   (blank_lz),
    .load       (load),
    .load_ack   (load_ack),
    .frame_tick (frame_tick),
    .an         (an),
    .seg_out    (seg_out),
    .dp_out     (dp_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [6:0] s3, input logic [6:0] s2,
                                       input logic [6:0] s1, input logic [6:0] s0,
                                       input logic [3:0] dpo, input logic ack);
    return {ack, dpo, s3, s2, s1, s0};
  endfunction

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (frame_tick) got = 1'b1;
    end
    if (!got) check("tick_timeout", 64'd0, 64'd1);
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] dp,
                            input logic err, input logic blz);
    value_in = v;
    dp_in    = dp;
    err_in   = err;
    blank_lz = blz;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // monitor: assembles one displayed frame per frame_tick and scores it
  initial begin
    prev_an   = 4'hF;
    seen      = '0;
    dp_seen   = '0;
    cyc_tick  = 0;
    cyc_digit = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_an   = 4'hF;
        seen      = '0;
        cyc_tick  = 0;
        cyc_digit = 0;
      end else begin
        cyc_tick++;
        cyc_digit++;
        if (an !== prev_an) begin
          exp_an = (prev_an == 4'hF) ? 4'b1110 : {prev_an[2:0], prev_an[3]};
          check("an_step", 64'(an), 64'(exp_an));
          if (prev_an != 4'hF) check("digit_len", 64'(cyc_digit), 64'(PRESCALE));
          dsel = 0;
          for (int j = 0; j < 4; j++) if (!an[j]) dsel = j;
          seg_seen[dsel] = seg_out;
          dp_seen[dsel]  = dp_out;
          seen[dsel]     = 1'b1;
          prev_an        = an;
          cyc_digit      = 0;
        end
        if (load_ack) check("ack_with_tick", 64'(frame_tick), 64'd1);
        if (frame_tick) begin
          check("frame_len", 64'(cyc_tick), 64'(DIGITS * PRESCALE));
          check("frame_digits", 64'(seen), 64'hF);
          obs = {load_ack, dp_seen, seg_seen[3], seg_seen[2], seg_seen[1], seg_seen[0]};
          if (exp_q.size() == 0) check("frame_unexpected", 64'd1, 64'd0);
          else check("frame", 64'(obs), 64'(exp_q.pop_front()));
          cyc_tick = 0;
          seen     = '0;
        end
      end
    end
  end

  // stimulus
  initial begin
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({an, seg_out, dp_out, load_ack, frame_tick}),
          64'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}));
    #2 rst_n = 1'b1;
    exp_q.push_back(mk(7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 1'b0));
    #1 check("pre_first_edge", 64'({an, seg_out}), 64'({4'hF, 7'h7F}));
    @(posedge clk);
    #1 check("first_edge", 64'({an, seg_out, dp_out}), 64'({4'b1110, 7'h40, 1'b1}));
    wait_tick();

    exp_q.push_back(mk(7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 1'b0));
    wait_tick();

    exp_q.push_back(mk(7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 1'b1));
    wait_cycles(6);
    drive_load(16'h1234, 4'h0, 1'b0, 1'b0);
    wait_tick();

    exp_q.push_back(mk(7'h79, 7'h24, 7'h30, 7'h19, 4'hF, 1'b0));
    wait_tick();

    exp_q.push_back(mk(7'h79, 7'h24, 7'h30, 7'h19, 4'hF, 1'b1));
    wait_cycles(2);
    drive_load(16'hAAAA, 4'h0, 1'b0, 1'b0);
    wait_cycles(5);
    drive_load(16'hBEEF, 4'h0, 1'b0, 1'b0);
    wait_tick();

    exp_q.push_back(mk(7'h03, 7'h06, 7'h06, 7'h0E, 4'hF, 1'b0));
    wait_tick();

    // second load lands on the boundary edge itself
    exp_q.push_back(mk(7'h03, 7'h06, 7'h06, 7'h0E, 4'hF, 1'b1));
    wait_cycles(2);
    drive_load(16'h0005, 4'h0, 1'b0, 1'b1);
    wait_cycles(12);
    value_in = 16'h0000;
    dp_in    = 4'b0010;
    err_in   = 1'b0;
    blank_lz = 1'b1;
    load     = 1'b1;
    wait_tick();
    load     = 1'b0;

    exp_q.push_back(mk(7'h7F, 7'h7F, 7'h7F, 7'h12, 4'hF, 1'b1));
    wait_tick();

    exp_q.push_back(mk(7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1101, 1'b1));
    wait_cycles(4);
    drive_load(16'h1234, 4'hF, 1'b1, 1'b0);
    wait_tick();

    exp_q.push_back(mk(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'hF, 1'b0));
    wait_tick();

    // mid-frame reset with a load still pending
    wait_cycles(2);
    drive_load(16'h5678, 4'h0, 1'b0, 1'b0);
    wait_cycles(3);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 64'({an, seg_out, dp_out, load_ack, frame_tick}),
             64'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    exp_q.push_back(mk(7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 1'b0));
    exp_q.push_back(mk(7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 1'b0));
    wait_tick();
    wait_tick();

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Parametrised, double-buffered, time-multiplexed seven-segment display controller for the board front panel. Scans DIGITS common-anode digits at a programmable rate and hex-decodes a packed value. Updates are tear-free: new values are staged and committed only at a frame boundary. Also provides leading-zero blanking, per-digit decimal points and an error pattern for the ALU overflow path.

## Interface
- DIGITS, 4, number of digits scanned, range 2..8
- PRESCALE, 100000, clk cycles each digit is driven, ≥ 2

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- value_in  in  4*DIGITS  packed hex nibbles; nibble i drives digit i, digit DIGITS-1 is most significant
- dp_in  in  DIGITS  decimal-point request per digit, 1 = lit
- err_in  in  1  error display request
- blank_lz  in  1  leading-zero suppression enable
- load  in  1  capture value_in/dp_in/err_in/blank_lz into staging
- load_ack  out  1  one-cycle pulse: staging committed to active
- frame_tick  out  1  one-cycle pulse per completed frame
- an  out  DIGITS  anode enables, active low
- seg_out  out  7  segments, active low, bit0 = a … bit6 = g
- dp_out  out  1  decimal point, active low

## Operation
- Prescaler counts 0..PRESCALE-1 and wraps. On wrap, digit index idx advances 0→1→…→DIGITS-1→0.
- Frame boundary: prescaler wraps while idx = DIGITS-1.
- Staging and active register sets each hold value, dp, err and blank_lz.
- Load handling:
  - load=1 writes staging and sets pending.
  - Further loads while pending overwrite staging; the latest value wins and only one ack is produced.
- Commit:
  - At a frame boundary with pending=1: active ← staging, pending ← 0.
  - load and boundary in the same cycle: the pre-edge staging is committed. The new load is captured and pending stays set for the next frame.
  - load at a boundary with pending=0: captured and committed at the following boundary.
- Digit rendering, for current idx:
  - active err=1: seg_out = dash (g only, 7'h3F), dp_out = 1, on every digit.
  - Otherwise, if blank_lz=1, idx ≠ 0, and all nibbles idx..DIGITS-1 are zero: seg_out = 7'h7F. dp still follows dp bit.
  - Otherwise: hex decode of nibble idx.
    - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
    - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - Digit 0 is never blanked.
- an = ~(1 << idx).

## Timing
- Reset (async assert, synchronous deassert handled upstream) drives:
  - an = all 1s, seg_out = 7'h7F, dp_out = 1, load_ack = 0, frame_tick = 0
  - prescaler = 0, idx = 0, pending = 0, staging and active all zero
- an, seg_out and dp_out are registered and reflect the previous cycle's idx/active state (1-cycle latency). The first edge after reset release gives an[0] low and seg_out = 7'h40.
- Each digit is driven for exactly PRESCALE cycles. A frame is DIGITS*PRESCALE cycles.
- frame_tick and load_ack are registered at the boundary edge, so they are high the following cycle.
  - load_ack coincides with frame_tick, only when a commit occurred.
  - The committed value appears on digit 0 one cycle after load_ack.
- Reset mid-frame: outputs go to reset values immediately and pending staging is discarded.

## Structure
- ssd_pkg holds:
  - the 16 hex segment constants
  - SEG_BLANK (7'h7F) and SEG_DASH (7'h3F)
  - a clog2-based width function for the prescaler and idx
- Sub-module hex_to_seg: purely combinational nibble → 7-bit active-low pattern, using ssd_pkg constants.
- The top level instantiates ssd_scan_ctrl with DIGITS=4 and feeds the ALU result plus overflow to err_in.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4.
- Reset release → an=1111, seg_out=7'h7F until the first edge; then an=1110, seg_out=7'h40.
- Free-run 32 cycles → an steps 1110, 1101, 1011, 0111 every 4 cycles; frame_tick high once per 16 cycles; load_ack never high.
- load with 16'h1234 mid-frame → display unchanged until the boundary; one load_ack with frame_tick; then digit 0 = 7'h19, digit 3 = 7'h79.
- load 16'hAAAA, then 16'hBEEF before the boundary → exactly one load_ack; digits show F,E,E,b (7'h0E, 06, 06, 03).
- blank_lz=1:
  - value 16'h0005 → digits 3..1 = 7'h7F, digit 0 = 7'h12
  - value 16'h0000 → digit 0 = 7'h40
  - dp_in=4'b0010 → dp_out=0 only while an=1101
- err_in=1 loaded → all digits 7'h3F, dp_out=1.
- Reset asserted mid-frame → outputs reset asynchronously and the pending load is lost.
